// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder arbiter slice.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: output-slot state enum, default datapath width, requester-tag width helper.
package adder_arb_pkg;

    // Default operand and sum width.
    localparam int ADDER_ARB_W = 64;

    // Output-slot occupancy: EMPTY means resp_valid=0, FULL means resp_valid=1.
    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Tag width for NREQ requesters, never narrower than one bit.
    function automatic int arb_idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared combinational W-bit adder; carry-out is dropped.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
//
// Ports: a, b (operands), out ((a+b) mod 2^W).
module adder_arbiter_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out
);

    assign out = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among NREQ requesters; result held in a one-entry slot.
// Latency: 1 cycle from accept (req_ready high at edge N) to resp_* valid after edge N.
// Backpressure: slot FULL with resp_ready=0 holds all outputs and drives req_ready=0; drain+refill in one cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b           per-requester operands
//   resp_valid/resp_ready  result handshake
//   resp_sum, resp_id      registered sum and index of the requester that produced it
//   resp_ovf               registered signed overflow (present only when ADDER_ARB_OVF_EN is defined)
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int W    = ADDER_ARB_W,
    localparam int IDW  = arb_idw(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][W-1:0]   req_a,
    input  logic [NREQ-1:0][W-1:0]   req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [W-1:0]             resp_sum,
    output logic [IDW-1:0]           resp_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                     resp_ovf
`endif
);

    arb_state_e     state_q;
    arb_state_e     state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] gnt_id;
    logic           gnt_found;
    logic           can_accept;
    logic           accept;
    logic [W-1:0]   gnt_a;
    logic [W-1:0]   gnt_b;
    logic [W-1:0]   sum;
    logic [IDW-1:0] rr_ptr_nxt;

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

    // The slot can take a new result when empty, or when it is being drained this cycle.
    assign can_accept = (state_q == ARB_EMPTY) || resp_ready;

    // rst_n gates req_ready so nothing is handshaken while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && can_accept && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept = |req_ready;

    // Granted operand mux feeding the single shared adder.
    assign gnt_a = req_a[gnt_id];
    assign gnt_b = req_b[gnt_id];

    adder_arbiter_adder #(
        .W (W)
    ) u_adder (
        .a   (gnt_a),
        .b   (gnt_b),
        .out (sum)
    );

    assign rr_ptr_nxt = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);

    // Slot occupancy FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: begin
                if (accept) begin
                    state_d = ARB_FULL;
                end
            end
            ARB_FULL: begin
                if (accept) begin
                    state_d = ARB_FULL;
                end else if (resp_ready) begin
                    state_d = ARB_EMPTY;
                end
            end
            default: state_d = ARB_EMPTY;
        endcase
    end

    assign resp_valid = (state_q == ARB_FULL);

    // Result register and round-robin pointer; both only move on accept,
    // so a drain without refill leaves sum and id holding their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sum <= '0;
            resp_id  <= '0;
            rr_ptr_q <= '0;
        end else if (accept) begin
            resp_sum <= sum;
            resp_id  <= gnt_id;
            rr_ptr_q <= rr_ptr_nxt;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    // Signed overflow: operands share a sign that the sum does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_ovf <= 1'b0;
        end else if (accept) begin
            resp_ovf <= (gnt_a[W-1] == gnt_b[W-1]) && (sum[W-1] != gnt_a[W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with NREQ=2, W=64.
// Latency: n/a (bench).
// Backpressure: n/a (bench); exercises stall, drain+refill and reset-while-full.
module tb_adder_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 64;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [W-1:0]           resp_sum;
    logic [0:0]             resp_id;
`ifdef ADDER_ARB_OVF_EN
    logic                   resp_ovf;
`endif

    int checks = 0;
    int errors = 0;

    adder_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
`ifdef ADDER_ARB_OVF_EN
        ,
        .resp_ovf   (resp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin expected grant order (pointer sits at 1 after the single-request test).
    logic [0:0] rr_exp_id [4];
    logic [63:0] rr_exp_sum [4];

    initial begin
        rr_exp_id[0] = 1'b1; rr_exp_sum[0] = 64'd202;
        rr_exp_id[1] = 1'b0; rr_exp_sum[1] = 64'd101;
        rr_exp_id[2] = 1'b1; rr_exp_sum[2] = 64'd202;
        rr_exp_id[3] = 1'b0; rr_exp_sum[3] = 64'd101;

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        // Reset state; req_ready must stay low even with requests pending.
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_sum", resp_sum, 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
`ifdef ADDER_ARB_OVF_EN
        check("rst_resp_ovf", 64'(resp_ovf), 64'd0);
`endif
        req_valid = 2'b00;
        #10;
        rst_n = 1'b1;
        step();

        // Single request from requester 0.
        req_valid  = 2'b01;
        req_a[0]   = 64'h1234567890ABCDEF;
        req_b[0]   = 64'hFEDCBA0987654321;
        resp_ready = 1'b1;
        #1;
        check("single_req_ready", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        check("single_valid", 64'(resp_valid), 64'd1);
        check("single_sum", resp_sum, 64'h1111108218111110);
        check("single_id", 64'(resp_id), 64'd0);
`ifdef ADDER_ARB_OVF_EN
        check("single_ovf", 64'(resp_ovf), 64'd0);
`endif
        step();
        check("drain_valid", 64'(resp_valid), 64'd0);
        check("drain_sum_hold", resp_sum, 64'h1111108218111110);

        // Round-robin with both requesters continuously valid.
        req_a[0] = 64'd100; req_b[0] = 64'd1;
        req_a[1] = 64'd200; req_b[1] = 64'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_req_ready", 64'(req_ready), 64'(rr_exp_id[i] ? 2'b10 : 2'b01));
            step();
            check("rr_resp_id", 64'(resp_id), 64'(rr_exp_id[i]));
            check("rr_resp_sum", resp_sum, rr_exp_sum[i]);
        end
        req_valid = 2'b00;
        step();

        // Backpressure: fill from requester 0, then stall with requester 1 pending.
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        step();
        req_valid = 2'b10;
        req_a[1]  = 64'h10;
        req_b[1]  = 64'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_sum", resp_sum, 64'd101);
            check("bp_id", 64'(resp_id), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        check("bp_new_valid", 64'(resp_valid), 64'd1);
        check("bp_new_sum", resp_sum, 64'h30);
        check("bp_new_id", 64'(resp_id), 64'd1);
        step();

        // Overflow corner cases; second result refills while the first drains.
        req_valid = 2'b01;
        req_a[0]  = 64'h7FFFFFFFFFFFFFFF;
        req_b[0]  = 64'd1;
        step();
        check("ovf_sum", resp_sum, 64'h8000000000000000);
`ifdef ADDER_ARB_OVF_EN
        check("ovf_flag", 64'(resp_ovf), 64'd1);
`endif
        req_valid = 2'b10;
        req_a[1]  = 64'hFFFFFFFFFFFFFFFF;
        req_b[1]  = 64'd1;
        step();
        check("carry_sum", resp_sum, 64'd0);
        check("carry_id", 64'(resp_id), 64'd1);
`ifdef ADDER_ARB_OVF_EN
        check("carry_ovf", 64'(resp_ovf), 64'd0);
`endif
        req_valid = 2'b00;
        step();

        // Reset while FULL; pointer is 1 before the reset.
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        req_a[0]   = 64'd5;
        req_b[0]   = 64'd6;
        step();
        req_valid = 2'b00;
        check("pre_rst_valid", 64'(resp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_sum", resp_sum, 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        check("post_rst_no_resp", 64'(resp_valid), 64'd0);
        req_a[0] = 64'd100; req_b[0] = 64'd1;
        req_a[1] = 64'd200; req_b[1] = 64'd2;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        check("post_rst_id", 64'(resp_id), 64'd0);
        check("post_rst_sum", resp_sum, 64'd101);

        // Idle: no requests for 10 cycles, pointer must stay at 1.
        step();
        for (int i = 0; i < 10; i++) begin
            check("idle_req_ready", 64'(req_ready), 64'd0);
            check("idle_valid", 64'(resp_valid), 64'd0);
            step();
        end
        req_valid = 2'b11;
        #1;
        check("idle_ptr_grant", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        check("idle_ptr_id", 64'(resp_id), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
